// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to a
// variable-latency instruction memory and buffers returned words for decode.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instruction,
  output logic [15:0] pc_plus_2,
  output logic        inst_valid
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [15:0]   fetch_pc;
  logic [15:0]   req_pc;
  logic          outstanding;
  logic          drop;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   instr_buf [DEPTH];
  logic [15:0]   pc2_buf   [DEPTH];

  logic resp;
  logic push;
  logic pop;

  assign imem_req   = !rst && !redirect && !outstanding && (count < FULL);
  assign imem_addr  = fetch_pc;
  assign resp       = imem_valid && outstanding;
  assign push       = resp && !drop && !redirect && !rst;
  assign inst_valid = !rst && (count != '0);
  assign pop        = inst_valid && !stall && !redirect;

  assign instruction = inst_valid ? instr_buf[rd_ptr] : 16'h0000;
  assign pc_plus_2   = inst_valid ? pc2_buf[rd_ptr]   : 16'h0000;

  // Redirect flushes the buffer and marks a still-pending fetch for discard.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC & 16'hFFFE;
      req_pc      <= 16'h0000;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 16'hFFFE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (resp) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end else if (outstanding) begin
        drop <= 1'b1;
      end
    end else begin
      if (imem_req) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + 16'd2;
      end
      if (resp) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_buf[wr_ptr] <= imem_rdata;
      pc2_buf[wr_ptr]   <= req_pc + 16'd2;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural instruction memory that
// returns 16'h1000 + address after a programmable latency.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instruction;
  logic [15:0] pc_plus_2;
  logic        inst_valid;

  int total = 0;
  int bad   = 0;

  int          mem_lat = 1;
  logic        busy = 1'b0;
  int          lat_cnt = 0;
  logic [15:0] pend_addr = 16'h0000;

  if_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instruction(instruction),
    .pc_plus_2  (pc_plus_2),
    .inst_valid (inst_valid)
  );

  always #5 clk = ~clk;

  // Memory model: one response per accepted request, mem_lat cycles later.
  always @(posedge clk) begin
    imem_valid <= 1'b0;
    if (rst) begin
      busy <= 1'b0;
    end else if (imem_req) begin
      pend_addr <= imem_addr;
      lat_cnt   <= mem_lat - 1;
      if (mem_lat == 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= 16'h1000 + imem_addr;
      end else begin
        busy <= 1'b1;
      end
    end else if (busy) begin
      if (lat_cnt == 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= 16'h1000 + pend_addr;
        busy       <= 1'b0;
      end
      lat_cnt <= lat_cnt - 1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; redirect = 1'b0; stall = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic release_reset();
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic next_cycle();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    mem_lat = 1;
    do_reset();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", inst_valid); end
    total++; if (instruction !== 16'h0000) begin bad++; $display("[TB] FAIL reset_instr: got %h want 0000", instruction); end
    total++; if (pc_plus_2 !== 16'h0000) begin bad++; $display("[TB] FAIL reset_pc2: got %h want 0000", pc_plus_2); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
  endtask

  task automatic test_stream();
    release_reset();
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("[TB] FAIL stream_req0: got %b/%h want 1/0000", imem_req, imem_addr); end
    next_cycle();
    total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_wait: got req=%b valid=%b want 0/0", imem_req, inst_valid); end
    next_cycle();
    total++; if (inst_valid !== 1'b1 || instruction !== 16'h1000 || pc_plus_2 !== 16'h0002) begin bad++; $display("[TB] FAIL stream_first: got %b %h/%h want 1 1000/0002", inst_valid, instruction, pc_plus_2); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin bad++; $display("[TB] FAIL stream_req2: got %b/%h want 1/0002", imem_req, imem_addr); end
    next_cycle();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_gap: got %b want 0", inst_valid); end
    next_cycle();
    total++; if (inst_valid !== 1'b1 || instruction !== 16'h1002 || pc_plus_2 !== 16'h0004) begin bad++; $display("[TB] FAIL stream_second: got %b %h/%h want 1 1002/0004", inst_valid, instruction, pc_plus_2); end
    total++; if (imem_addr !== 16'h0004) begin bad++; $display("[TB] FAIL stream_addr4: got %h want 0004", imem_addr); end
  endtask

  task automatic test_stall_fill();
    mem_lat = 1;
    do_reset();
    release_reset();
    next_cycle();
    @(negedge clk); stall = 1'b1; #1;
    total++; if (instruction !== 16'h1000 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin bad++; $display("[TB] FAIL fill_c2: got %h req=%b addr=%h want 1000 1 0002", instruction, imem_req, imem_addr); end
    next_cycle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL fill_c3_req: got %b want 0", imem_req); end
    next_cycle();
    total++; if (imem_req !== 1'b0 || instruction !== 16'h1000 || pc_plus_2 !== 16'h0002) begin bad++; $display("[TB] FAIL fill_full: got req=%b %h/%h want 0 1000/0002", imem_req, instruction, pc_plus_2); end
    @(negedge clk); stall = 1'b0; #1;
    total++; if (imem_req !== 1'b0 || instruction !== 16'h1000 || pc_plus_2 !== 16'h0002) begin bad++; $display("[TB] FAIL fill_held: got req=%b %h/%h want 0 1000/0002", imem_req, instruction, pc_plus_2); end
    next_cycle();
    total++; if (inst_valid !== 1'b1 || instruction !== 16'h1002 || pc_plus_2 !== 16'h0004) begin bad++; $display("[TB] FAIL fill_pop2: got %b %h/%h want 1 1002/0004", inst_valid, instruction, pc_plus_2); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin bad++; $display("[TB] FAIL fill_resume: got %b/%h want 1/0004", imem_req, imem_addr); end
    next_cycle();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL fill_empty: got %b want 0", inst_valid); end
    next_cycle();
    total++; if (instruction !== 16'h1004 || pc_plus_2 !== 16'h0006) begin bad++; $display("[TB] FAIL fill_third: got %h/%h want 1004/0006", instruction, pc_plus_2); end
  endtask

  task automatic test_redirect_inflight();
    mem_lat = 3;
    do_reset();
    release_reset();
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0041; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rinf_req: got %b want 0", imem_req); end
    @(negedge clk); redirect = 1'b0; #1;
    total++; if (imem_addr !== 16'h0040 || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rinf_addr: got %h req=%b want 0040 0", imem_addr, imem_req); end
    next_cycle();
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rinf_late: got valid=%b req=%b want 0/0", inst_valid, imem_req); end
    next_cycle();
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin bad++; $display("[TB] FAIL rinf_refetch: got valid=%b req=%b addr=%h want 0 1 0040", inst_valid, imem_req, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL rinf_wait%0d: got %b want 0", i, inst_valid); end
    end
    next_cycle();
    total++; if (inst_valid !== 1'b1 || instruction !== 16'h1040 || pc_plus_2 !== 16'h0042) begin bad++; $display("[TB] FAIL rinf_out: got %b %h/%h want 1 1040/0042", inst_valid, instruction, pc_plus_2); end
  endtask

  task automatic test_redirect_coincident();
    mem_lat = 1;
    do_reset();
    release_reset();
    next_cycle();
    @(negedge clk); stall = 1'b1; #1;
    total++; if (instruction !== 16'h1000) begin bad++; $display("[TB] FAIL rco_head: got %h want 1000", instruction); end
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0080; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rco_req: got %b want 0", imem_req); end
    @(negedge clk); redirect = 1'b0; #1;
    total++; if (inst_valid !== 1'b0 || instruction !== 16'h0000 || pc_plus_2 !== 16'h0000) begin bad++; $display("[TB] FAIL rco_flush: got %b %h/%h want 0 0000/0000", inst_valid, instruction, pc_plus_2); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin bad++; $display("[TB] FAIL rco_next: got %b/%h want 1/0080", imem_req, imem_addr); end
    next_cycle();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL rco_wait: got %b want 0", inst_valid); end
    next_cycle();
    total++; if (inst_valid !== 1'b1 || instruction !== 16'h1080 || pc_plus_2 !== 16'h0082) begin bad++; $display("[TB] FAIL rco_out: got %b %h/%h want 1 1080/0082", inst_valid, instruction, pc_plus_2); end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    do_reset();
    @(negedge clk); rst = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFE; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL wrap_redir_req: got %b want 0", imem_req); end
    @(negedge clk); redirect = 1'b0; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin bad++; $display("[TB] FAIL wrap_req: got %b/%h want 1/fffe", imem_req, imem_addr); end
    next_cycle();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_wait: got %b want 0", inst_valid); end
    next_cycle();
    total++; if (inst_valid !== 1'b1 || instruction !== 16'h0FFE || pc_plus_2 !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_out: got %b %h/%h want 1 0ffe/0000", inst_valid, instruction, pc_plus_2); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_next: got %b/%h want 1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    mem_lat = 1;
    do_reset();
    release_reset();
    next_cycle();
    @(negedge clk); stall = 1'b1; #1;
    total++; if (inst_valid !== 1'b1 || instruction !== 16'h1000) begin bad++; $display("[TB] FAIL rmid_pre: got %b %h want 1 1000", inst_valid, instruction); end
    // Buffer holds one word and the second response is on the bus this cycle.
    @(negedge clk); rst = 1'b1; #1;
    total++; if (inst_valid !== 1'b0 || instruction !== 16'h0000 || pc_plus_2 !== 16'h0000 || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rmid_in_rst: got %b %h/%h req=%b want 0 0000/0000 0", inst_valid, instruction, pc_plus_2, imem_req); end
    @(negedge clk); rst = 1'b0; stall = 1'b0; #1;
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("[TB] FAIL rmid_after: got valid=%b req=%b addr=%h want 0 1 0000", inst_valid, imem_req, imem_addr); end
    next_cycle();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_discard: got %b want 0", inst_valid); end
    next_cycle();
    total++; if (inst_valid !== 1'b1 || instruction !== 16'h1000 || pc_plus_2 !== 16'h0002) begin bad++; $display("[TB] FAIL rmid_out: got %b %h/%h want 1 1000/0002", inst_valid, instruction, pc_plus_2); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect_inflight();
    test_redirect_coincident();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
